serial_subtractor: RTL and testbench

- Bit-serial subtractor computing DIFF = A − B over WIDTH cycles, LSB first.
- Two's-complement form: A + ~B + 1, built around one instance of the existing single-bit Full_Adder cell plus a carry flip-flop.
- This is the inverse-direction companion to the adder datapath. It sits behind a start/done handshake so a controller can request one subtraction at a time.

---
 rtl/serial_subtractor_pkg.sv | 12 +
 rtl/Full_Adder.sv | 13 +
 rtl/serial_subtractor.sv | 103 ++++++++++
 tb/tb_serial_subtractor.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM encoding and default width.
package serial_subtractor_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/Full_Adder.sv
// Single-bit full adder cell reused from the adder datapath.
module Full_Adder (
    input  logic A,
    input  logic B,
    input  logic Carry_in,
    output logic Sum,
    output logic Carry_out
);

    assign Sum       = A ^ B ^ Carry_in;
    assign Carry_out = (A & B) | (A & Carry_in) | (B & Carry_in);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial A - B computed LSB first as A + ~B + 1 through one full adder and a carry flop.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             overflow
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res_sr;
    logic [CNT_W-1:0] cnt;
    logic             carry;
    logic             c_msb_in;
    logic             fa_sum;
    logic             fa_cout;
    logic             done_q;
    logic [WIDTH-1:0] diff_q;
    logic             borrow_q;
    logic             overflow_q;

    Full_Adder u_fa (a_sr[0], b_sr[0], carry, fa_sum, fa_cout);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = SHIFT;
            SHIFT:   if (cnt == LAST_BIT) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Results are published one edge after entering DONE, once the last sum bit has landed
    // in res_sr and the final carry sits in the carry flop.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            a_sr       <= '0;
            b_sr       <= '0;
            res_sr     <= '0;
            cnt        <= '0;
            carry      <= 1'b0;
            c_msb_in   <= 1'b0;
            done_q     <= 1'b0;
            diff_q     <= '0;
            borrow_q   <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            done_q <= (state == DONE);
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sr  <= a_in;
                        b_sr  <= ~b_in;
                        carry <= 1'b1;
                        cnt   <= '0;
                    end
                end
                SHIFT: begin
                    a_sr   <= {1'b0, a_sr[WIDTH-1:1]};
                    b_sr   <= {1'b0, b_sr[WIDTH-1:1]};
                    res_sr <= {fa_sum, res_sr[WIDTH-1:1]};
                    carry  <= fa_cout;
                    if (cnt == LAST_BIT) begin
                        c_msb_in <= carry;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                DONE: begin
                    diff_q     <= res_sr;
                    borrow_q   <= ~carry;
                    overflow_q <= c_msb_in ^ carry;
                end
                default: ;
            endcase
        end
    end

    assign busy     = (state != IDLE) || done_q;
    assign done     = done_q;
    assign diff     = diff_q;
    assign borrow   = borrow_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor with an expected-result queue filled at each accepted start.
module tb_serial_subtractor;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a_in;
    logic [W-1:0] b_in;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         borrow;
    logic         overflow;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int start_cyc = 0;
    int done_pulses = 0;

    logic [W+1:0] exp_q[$];

    serial_subtractor #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .a_in     (a_in),
        .b_in     (b_in),
        .busy     (busy),
        .done     (done),
        .diff     (diff),
        .borrow   (borrow),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (done) done_pulses <= done_pulses + 1;
    end

    // Reference: {diff, unsigned borrow, signed overflow} for A - B.
    function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] d;
        logic         brw;
        logic         ovf;
        d   = a - b;
        brw = (a < b);
        ovf = (a[W-1] != b[W-1]) && (d[W-1] != a[W-1]);
        return {d, brw, ovf};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic collect(input string tag);
        logic [W+1:0] e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s: unexpected done, expected-queue empty", tag);
        end else begin
            e = exp_q.pop_front();
            chk({tag, "_diff"}, 32'(diff), 32'(e[W+1:2]));
            chk({tag, "_borrow"}, 32'(borrow), 32'(e[1]));
            chk({tag, "_overflow"}, 32'(overflow), 32'(e[0]));
            chk({tag, "_busy"}, 32'(busy), 32'd1);
        end
    endtask

    task automatic wait_done(input string tag);
        logic [W-1:0] held;
        for (int n = 0; n < 4 * W; n++) begin
            step();
            if (done) begin
                chk({tag, "_latency"}, 32'(cyc - start_cyc), 32'(W + 1));
                collect(tag);
                held = diff;
                step();
                chk({tag, "_pulse_end"}, 32'(done), 32'd0);
                chk({tag, "_held"}, 32'(diff), 32'(held));
                return;
            end
        end
        checks++;
        errors++;
        $error("FAIL %s: no done within %0d cycles", tag, 4 * W);
    endtask

    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input string tag);
        a_in  = a;
        b_in  = b;
        start = 1'b1;
        step();
        start = 1'b0;
        start_cyc = cyc;
        exp_q.push_back(model(a, b));
        wait_done(tag);
    endtask

    initial begin
        int pulses_before;
        int seen;
        rst_n = 1'b0;
        start = 1'b0;
        a_in  = '0;
        b_in  = '0;
        repeat (3) step();
        rst_n = 1'b1;
        repeat (5) step();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_diff", 32'(diff), 32'd0);
        chk("rst_borrow", 32'(borrow), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);

        do_op(8'h2D, 8'h0F, "basic");
        do_op(8'h05, 8'h07, "a_lt_b");
        do_op(8'h80, 8'h01, "neg_ovf");
        do_op(8'h7F, 8'hFF, "pos_ovf");
        do_op(8'h6C, 8'h6C, "a_eq_b");
        do_op(8'hC3, 8'h00, "b_zero");
        for (int i = 0; i < 4; i++) begin
            do_op(W'($urandom_range(0, 255)), W'($urandom_range(0, 255)), "rand");
        end

        // A start pulse mid-SHIFT with new operands must not disturb the running op.
        a_in  = 8'h10;
        b_in  = 8'h01;
        start = 1'b1;
        step();
        start = 1'b0;
        start_cyc = cyc;
        exp_q.push_back(model(8'h10, 8'h01));
        repeat (3) step();
        a_in  = 8'hAA;
        b_in  = 8'h5C;
        start = 1'b1;
        step();
        start = 1'b0;
        wait_done("ignored_start");
        chk("ignored_diff_value", 32'(diff), 32'h0F);

        // Start held high: the second request is only taken once back in IDLE.
        pulses_before = done_pulses;
        seen = 0;
        a_in  = 8'h40;
        b_in  = 8'h03;
        start = 1'b1;
        step();
        start_cyc = cyc;
        exp_q.push_back(model(8'h40, 8'h03));
        a_in = 8'h21;
        b_in = 8'h09;
        exp_q.push_back(model(8'h21, 8'h09));
        for (int n = 1; n <= 3 * W + 6; n++) begin
            step();
            if (n == W + 2) start = 1'b0;
            if (done) begin
                seen++;
                chk("b2b_latency", 32'(cyc - start_cyc), (seen == 1) ? 32'(W + 1) : 32'(2 * W + 3));
                collect("b2b");
            end
        end
        chk("b2b_pulses", 32'(done_pulses - pulses_before), 32'd2);

        // Reset at cnt = 3 aborts the op with no done.
        a_in  = 8'h5A;
        b_in  = 8'h13;
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (3) step();
        rst_n = 1'b0;
        step();
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_diff", 32'(diff), 32'd0);
        chk("abort_borrow", 32'(borrow), 32'd0);
        chk("abort_overflow", 32'(overflow), 32'd0);
        rst_n = 1'b1;
        pulses_before = done_pulses;
        repeat (2 * W) step();
        chk("abort_no_done", 32'(done_pulses - pulses_before), 32'd0);
        do_op(8'h33, 8'h11, "after_abort");
        chk("after_abort_value", 32'(diff), 32'h22);

        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
